// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, ISSUE, WAIT)
//   ADDR_W_DEF  : default memory address width
//   DATA_W_DEF  : default memory data width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority picker.
// Returns the first set bit of pending_i at or after ptr_i, wrapping modulo N.
//   pending_i : request vector
//   ptr_i     : index with highest priority this cycle (must be < N)
//   valid_o   : at least one bit of pending_i is set
//   idx_o     : selected index (0 when valid_o is low)
module rr_select #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        // Walk from the farthest offset down to zero so the nearest pending
        // index is the last one written and therefore wins.
        for (int off = N - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (pending_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NUM_REQ requesters
// (0 = init loader, 1 = CPU, 2 = display fetch). One transaction in flight at
// a time; completion and read data are routed back to the owner, and a hung
// controller is released after TIMEOUT cycles in WAIT.
//   req_en/req_r_en/req_w_en/req_addr/req_data : requester side inputs
//   req_ack, req_cplt, req_data_out            : requester side outputs
//   mem_addr, mem_data_in, mem_r_en, mem_w_en  : to controller
//   mem_rdy, mem_cplt, mem_data_out            : from controller
//   busy, gnt_id, timeout_err                  : status
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int TIMEOUT    = 1024,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(TIMEOUT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_en,
    input  logic [NUM_REQ-1:0]            req_r_en,
    input  logic [NUM_REQ-1:0]            req_w_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_cplt,
    output logic [DATA_WIDTH-1:0]         req_data_out,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    output logic                          mem_r_en,
    output logic                          mem_w_en,
    input  logic                          mem_rdy,
    input  logic                          mem_cplt,
    input  logic [DATA_WIDTH-1:0]         mem_data_out,
    output logic                          busy,
    output logic [IDX_W-1:0]              gnt_id,
    output logic                          timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_REQ-1:0]    pending;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic                  in_wait;
    logic                  cnt_expired;

    assign pending = req_en & (req_r_en | req_w_en);

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .pending_i (pending),
        .ptr_i     (rr_ptr_q),
        .valid_o   (sel_valid),
        .idx_o     (sel_idx)
    );

    assign in_wait     = (state_q == WAIT);
    assign cnt_expired = in_wait && (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        cnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (mem_rdy && sel_valid) begin
                    gnt_d   = sel_idx;
                    addr_d  = req_addr[int'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_data[int'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];
                    // A simultaneous read and write request is treated as a write.
                    is_wr_d = req_w_en[sel_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_cplt || cnt_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Strobes, ack and completion are decoded straight from state so they
    // line up with the ISSUE/WAIT cycles without an extra register stage.
    assign gnt_onehot   = NUM_REQ'(1) << gnt_q;
    assign busy         = (state_q != IDLE);
    assign mem_r_en     = (state_q == ISSUE) && !is_wr_q;
    assign mem_w_en     = (state_q == ISSUE) && is_wr_q;
    assign req_ack      = (state_q == ISSUE) ? gnt_onehot : '0;
    // A completion arriving on the last allowed cycle beats the timeout.
    assign timeout_err  = cnt_expired && !mem_cplt;
    assign req_cplt     = (in_wait && (mem_cplt || cnt_expired)) ? gnt_onehot : '0;
    assign req_data_out = (in_wait && !timeout_err) ? mem_data_out : '0;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign gnt_id       = gnt_q;

endmodule
